adc_frame_packer: RTL and testbench

- Downstream of the AD9252 receive wrapper, in the frame-clock domain (adc_fclk).
- Takes the aligned parallel samples and their write-valid strobe, and groups the sample stream into fixed-length frames.
- Tags each word with SOF/EOF flags and a frame sequence number, then writes 64-bit words into the external data FIFO.
- Handles FIFO back-pressure by dropping whole-frame remainders, and aborts cleanly on loss of alignment.

---
 rtl/adc_pack_pkg.sv | 19 +
 rtl/adc_frame_packer_if.sv | 24 ++
 rtl/adc_lane_tagger.sv | 23 ++
 rtl/adc_frame_packer.sv | 145 ++++++++++++++
 tb/tb_adc_frame_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_pack_pkg.sv
// Shared constants and state encoding for the ADC frame packer.
package adc_pack_pkg;

    localparam int ADC_CHANEL = 4;   // channels per sample; the 64-bit layout assumes 4
    localparam int CH_W       = 14;  // ADC sample width
    localparam int TAG_W      = 2;   // tag bits on top of each lane
    localparam int LANE_W     = CH_W + TAG_W;
    localparam int WORD_W     = 64;  // FIFO word width
    localparam int SEQ_W      = 6;   // frame sequence number, spread over lanes 1-3 tags

    // Encoding is visible on pack_state for the ILA, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DROP  = 2'd3
    } pack_state_e;

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample-in / FIFO-out bus of the frame packer.
interface adc_frame_packer_if;
    import adc_pack_pkg::*;

    logic [ADC_CHANEL*CH_W-1:0] adc_data_allch;  // ch i at [14i+13:14i]
    logic                       data_valid;
    logic                       data_aligned;
    logic                       fifo_full;
    logic [WORD_W-1:0]          fifo_din;
    logic                       fifo_wren;

    // Packer side: consumes samples, drives the FIFO.
    modport slave (
        input  adc_data_allch, data_valid, data_aligned, fifo_full,
        output fifo_din, fifo_wren
    );

    // Upstream/FIFO side: drives samples, receives words.
    modport master (
        output adc_data_allch, data_valid, data_aligned, fifo_full,
        input  fifo_din, fifo_wren
    );

endinterface

// File: rtl/adc_lane_tagger.sv
// Combinational packing of one 4-channel sample plus SOF/EOF/seq tags
// into a 64-bit FIFO word: lane i = {tag_i, ch_i}.
module adc_lane_tagger
    import adc_pack_pkg::*;
(
    input  logic [ADC_CHANEL*CH_W-1:0] samples_i,
    input  logic                       sof_i,
    input  logic                       eof_i,
    input  logic [SEQ_W-1:0]           seq_i,
    output logic [WORD_W-1:0]          word_o
);

    // Lane 0 carries {SOF, EOF}; lanes 1-3 carry seq two bits each, LSBs first.
    always_comb begin
        // NOTE: assign a default first so no path through the block leaves the output unassigned (no latch).
        word_o = '0;
        word_o[LANE_W-1:0] = {sof_i, eof_i, samples_i[CH_W-1:0]};
        for (int i = 1; i < ADC_CHANEL; i++) begin
            word_o[LANE_W*i +: LANE_W] = {seq_i[TAG_W*(i-1) +: TAG_W], samples_i[CH_W*i +: CH_W]};
        end
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Groups the aligned ADC sample stream into FRAME_LEN-sample frames, tags
// SOF/EOF/seq and writes 64-bit words to the data FIFO. A full FIFO drops
// the rest of the frame; loss of alignment abandons the frame.
module adc_frame_packer
    import adc_pack_pkg::*;
#(
    parameter int FRAME_LEN = 1024  // 2..65535
) (
    input  logic                clk_ref,
    input  logic                reset,
    input  logic                soft_start,
    adc_frame_packer_if.slave   bus,
    output logic [31:0]         frame_cnt,
    output logic [15:0]         drop_cnt,
    output logic [1:0]          pack_state
);

    localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

    pack_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              wren_q;

    logic              last;
    logic              write;
    logic              abort;
    logic              sof;
    logic              eof;
    logic [WORD_W-1:0] word;
    pack_state_e       after_frame;

    assign last        = (cnt_q == LAST_CNT);
    assign after_frame = soft_start ? ST_RUN : ST_ARMED;

    adc_lane_tagger u_tagger (
        .samples_i (bus.adc_data_allch),
        .sof_i     (sof),
        .eof_i     (eof),
        .seq_i     (seq_q),
        .word_o    (word)
    );

    // State register.
    always_ff @(posedge clk_ref or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; alignment loss overrides everything.
    always_comb begin
        state_d = state_q;
        if (!bus.data_aligned) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_ARMED;
                ST_ARMED: if (soft_start && bus.data_valid && !bus.fifo_full) state_d = ST_RUN;
                ST_RUN: begin
                    // A dropped last sample ends the frame with nothing left to skip.
                    if (bus.data_valid && last)                state_d = after_frame;
                    else if (bus.data_valid && bus.fifo_full)  state_d = ST_DROP;
                end
                ST_DROP:  if (bus.data_valid && last) state_d = after_frame;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Write strobe, flags and counter updates for the current state.
    always_comb begin
        write       = 1'b0;
        abort       = 1'b0;
        sof         = 1'b0;
        eof         = 1'b0;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (state_q != ST_IDLE && !bus.data_aligned) begin
            abort = 1'b1;
            cnt_d = '0;
        end else if (bus.data_valid) begin
            unique case (state_q)
                ST_ARMED: begin
                    if (soft_start && !bus.fifo_full) begin
                        write = 1'b1;
                        sof   = 1'b1;
                        cnt_d = 16'd1;
                    end
                end
                ST_RUN: begin
                    if (!bus.fifo_full) begin
                        write = 1'b1;
                        sof   = (cnt_q == '0);
                        eof   = last;
                        if (last) begin
                            frame_cnt_d = frame_cnt_q + 32'd1;
                            seq_d       = seq_q + 1'b1;
                        end
                    end else begin
                        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        seq_d      = seq_q + 1'b1;
                    end
                    cnt_d = last ? '0 : cnt_q + 16'd1;
                end
                ST_DROP:  cnt_d = last ? '0 : cnt_q + 16'd1;
                default:  cnt_d = cnt_q;
            endcase
        end
        // Hold the last word between writes; clear it when a frame is abandoned.
        dout_d = abort ? '0 : (write ? word : dout_q);
    end

    // Counters and the registered FIFO output.
    always_ff @(posedge clk_ref or negedge reset) begin
        // NOTE: every register here is a small flop with an async clear, so all of them are reset.
        if (!reset) begin
            cnt_q       <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            dout_q      <= '0;
            wren_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            dout_q      <= dout_d;
            wren_q      <= write;
        end
    end

    assign bus.fifo_din  = dout_q;
    assign bus.fifo_wren = wren_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign pack_state    = state_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with FRAME_LEN=4; ch1..ch3 fixed at 2..4,
// ch0 carries the in-frame sample number 1..4.
module tb_adc_frame_packer;

    logic        clk_ref = 1'b0;
    logic        reset;
    logic        soft_start;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [1:0]  pack_state;
    int          checks   = 0;
    int          failures = 0;

    adc_frame_packer_if bus();

    adc_frame_packer #(.FRAME_LEN(4)) dut (
        .clk_ref    (clk_ref),
        .reset      (reset),
        .soft_start (soft_start),
        .bus        (bus),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt),
        .pack_state (pack_state)
    );

    always #5 clk_ref = ~clk_ref;

    // Expected word: lane3..1 = {seq pair, ch 4/3/2}, lane0 = {SOF, EOF, ch0}.
    function automatic logic [63:0] exp_word(input logic s, input logic e,
                                             input logic [5:0] seq, input logic [13:0] c0);
        return {seq[5:4], 14'd4, seq[3:2], 14'd3, seq[1:0], 14'd2, s, e, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [13:0] c0);
        bus.data_valid     = v;
        bus.fifo_full      = f;
        bus.adc_data_allch = {14'd4, 14'd3, 14'd2, c0};
    endtask

    // Apply inputs, clock once, land 1 ns after the edge for checking.
    task automatic cyc(input logic v, input logic f, input logic [13:0] c0);
        drive(v, f, c0);
        @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 14'd0);
        bus.data_aligned = 1'b0;
        soft_start       = 1'b0;
        reset            = 1'b0;
        @(posedge clk_ref);
        #2 reset = 1'b1;
    endtask

    task automatic arm();
        bus.data_aligned = 1'b1;
        soft_start       = 1'b1;
        cyc(1'b0, 1'b0, 14'd0);
    endtask

    task automatic full_frame();
        for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, 14'(k));
    endtask

    initial begin
        reset            = 1'b0;
        soft_start       = 1'b0;
        bus.data_aligned = 1'b0;
        drive(1'b0, 1'b0, 14'd0);
        #3;
        chk("rst_din",   bus.fifo_din, 64'd0);
        chk("rst_wren",  64'(bus.fifo_wren), 64'd0);
        chk("rst_frame", 64'(frame_cnt), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_state", 64'(pack_state), 64'd0);
        #9 reset = 1'b1;

        // Basic frame
        arm();
        chk("armed_state", 64'(pack_state), 64'd1);
        cyc(1'b1, 1'b0, 14'd1);
        chk("sof_word",  bus.fifo_din, 64'h0004_0003_0002_8001);
        chk("sof_wren",  64'(bus.fifo_wren), 64'd1);
        chk("run_state", 64'(pack_state), 64'd2);
        cyc(1'b1, 1'b0, 14'd2);
        chk("mid_word", bus.fifo_din, exp_word(1'b0, 1'b0, 6'd0, 14'd2));
        cyc(1'b1, 1'b0, 14'd3);
        cyc(1'b1, 1'b0, 14'd4);
        chk("eof_word",   bus.fifo_din, 64'h0004_0003_0002_4004);
        chk("eof_frames", 64'(frame_cnt), 64'd1);
        cyc(1'b1, 1'b0, 14'd1);
        chk("seq1_word", bus.fifo_din, 64'h0004_0003_4002_8001);

        // Back-pressure on sample 2
        do_reset();
        arm();
        cyc(1'b1, 1'b0, 14'd1);
        cyc(1'b1, 1'b0, 14'd2);
        cyc(1'b1, 1'b1, 14'd3);
        chk("bp_wren",  64'(bus.fifo_wren), 64'd0);
        chk("bp_drop",  64'(drop_cnt), 64'd1);
        chk("bp_state", 64'(pack_state), 64'd3);
        cyc(1'b1, 1'b0, 14'd4);
        chk("bp_skip_wren", 64'(bus.fifo_wren), 64'd0);
        chk("bp_run_state", 64'(pack_state), 64'd2);
        chk("bp_frames",    64'(frame_cnt), 64'd0);
        cyc(1'b1, 1'b0, 14'd1);
        chk("bp_next_sof", bus.fifo_din, exp_word(1'b1, 1'b0, 6'd1, 14'd1));
        chk("bp_next_wren", 64'(bus.fifo_wren), 64'd1);

        // Full on the EOF sample
        do_reset();
        arm();
        cyc(1'b1, 1'b0, 14'd1);
        cyc(1'b1, 1'b0, 14'd2);
        cyc(1'b1, 1'b0, 14'd3);
        cyc(1'b1, 1'b1, 14'd4);
        chk("eoffull_wren",   64'(bus.fifo_wren), 64'd0);
        chk("eoffull_drop",   64'(drop_cnt), 64'd1);
        chk("eoffull_frames", 64'(frame_cnt), 64'd0);
        chk("eoffull_state",  64'(pack_state), 64'd2);
        cyc(1'b1, 1'b0, 14'd1);
        chk("eoffull_next", bus.fifo_din, exp_word(1'b1, 1'b0, 6'd1, 14'd1));

        // Full at the start of two consecutive frames
        do_reset();
        arm();
        full_frame();
        cyc(1'b1, 1'b1, 14'd1);
        chk("fs1_drop",  64'(drop_cnt), 64'd1);
        chk("fs1_state", 64'(pack_state), 64'd3);
        for (int k = 2; k <= 4; k++) cyc(1'b1, 1'b0, 14'(k));
        chk("fs1_wren",  64'(bus.fifo_wren), 64'd0);
        cyc(1'b1, 1'b1, 14'd1);
        chk("fs2_drop",  64'(drop_cnt), 64'd2);
        for (int k = 2; k <= 4; k++) cyc(1'b1, 1'b0, 14'(k));
        chk("fs2_wren",  64'(bus.fifo_wren), 64'd0);
        cyc(1'b1, 1'b0, 14'd1);
        chk("fs_resume_word", bus.fifo_din, exp_word(1'b1, 1'b0, 6'd3, 14'd1));
        chk("fs_frames", 64'(frame_cnt), 64'd1);

        // Alignment loss at sample 1 of the seq=1 frame
        do_reset();
        arm();
        full_frame();
        cyc(1'b1, 1'b0, 14'd1);
        bus.data_aligned = 1'b0;
        cyc(1'b1, 1'b0, 14'd2);
        chk("al_state",  64'(pack_state), 64'd0);
        chk("al_wren",   64'(bus.fifo_wren), 64'd0);
        chk("al_din",    bus.fifo_din, 64'd0);
        chk("al_frames", 64'(frame_cnt), 64'd1);
        chk("al_drop",   64'(drop_cnt), 64'd0);
        bus.data_aligned = 1'b1;
        cyc(1'b0, 1'b0, 14'd0);
        chk("al_rearm", 64'(pack_state), 64'd1);
        cyc(1'b1, 1'b0, 14'd1);
        chk("al_reuse_seq", bus.fifo_din, exp_word(1'b1, 1'b0, 6'd1, 14'd1));

        // soft_start falls mid-frame: frame completes, then wait in ARMED
        soft_start = 1'b0;
        cyc(1'b1, 1'b0, 14'd2);
        cyc(1'b1, 1'b0, 14'd3);
        cyc(1'b1, 1'b0, 14'd4);
        chk("ss_eof_word", bus.fifo_din, exp_word(1'b0, 1'b1, 6'd1, 14'd4));
        chk("ss_state",    64'(pack_state), 64'd1);
        chk("ss_frames",   64'(frame_cnt), 64'd2);
        cyc(1'b1, 1'b0, 14'd1);
        chk("ss_hold_wren", 64'(bus.fifo_wren), 64'd0);
        soft_start = 1'b1;
        cyc(1'b1, 1'b0, 14'd1);
        chk("ss_restart", bus.fifo_din, exp_word(1'b1, 1'b0, 6'd2, 14'd1));

        // Gapped valid
        cyc(1'b0, 1'b0, 14'd2);
        chk("gap0_wren", 64'(bus.fifo_wren), 64'd0);
        cyc(1'b1, 1'b0, 14'd2);
        chk("gap1_word", bus.fifo_din, exp_word(1'b0, 1'b0, 6'd2, 14'd2));
        chk("gap1_wren", 64'(bus.fifo_wren), 64'd1);
        cyc(1'b0, 1'b0, 14'd3);
        chk("gap2_wren", 64'(bus.fifo_wren), 64'd0);
        cyc(1'b1, 1'b0, 14'd3);
        chk("gap3_word", bus.fifo_din, exp_word(1'b0, 1'b0, 6'd2, 14'd3));

        // Asynchronous reset mid-frame, checked between clock edges
        #2 reset = 1'b0;
        #1;
        chk("arst_din",   bus.fifo_din, 64'd0);
        chk("arst_wren",  64'(bus.fifo_wren), 64'd0);
        chk("arst_frame", 64'(frame_cnt), 64'd0);
        chk("arst_drop",  64'(drop_cnt), 64'd0);
        chk("arst_state", 64'(pack_state), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
